video_timing_gen: RTL

//  Raster timing generator and pixel-pipeline aligner feeding the DVI output stage.
//  - Generates the h/v counters, pixel requests and X/Y coordinates for the upstream pixel source (text/glyph renderer).
//  - Delays hsync/vsync/de by the source's fixed read latency so sync, DE and RGB leave this block cycle-aligned.
//  - Outputs drive the DVI stage's hsync_in/vsync_in/de_in/red_in/green_in/blue_in directly.

---
 rtl/video_timing_pkg.sv | 39 +++
 rtl/vt_delay_line.sv | 34 +++
 rtl/video_timing_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and mode constants for the raster timing generator.
package video_timing_pkg;

  // Sync/enable bundle carried down the pixel-latency pipeline (active-true encoding).
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam int unsigned SYNC_W = $bits(sync_t);

  // Total line/frame length from the four segment widths.
  function automatic int unsigned timing_total(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
    return a + b + c + d;
  endfunction

  // 640x480 @ 60 Hz
  localparam int unsigned VGA_H_ACTIVE  = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_ACTIVE  = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  // 800x600 @ 60 Hz
  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BP     = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BP     = 23;

endpackage

// File: rtl/vt_delay_line.sv
// Fixed-depth shift register that matches sync timing to the pixel source latency.
module vt_delay_line
  import video_timing_pkg::*;
#(
  parameter int unsigned WIDTH = SYNC_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_sr
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one stage per clock; reset clears every stage to inactive.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, stage-0 pixel requests and latency-aligned sync/DE/RGB output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned PIX_LAT  = 2
) (
  input  logic        gpu_clk0,
  input  logic        Rst_n,
  input  logic        enable,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        line_start,
  output logic        frame_start,
  input  logic [7:0]  pix_red,
  input  logic [7:0]  pix_green,
  input  logic [7:0]  pix_blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out
);

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             run;
  sync_t            raw_sync;
  sync_t            dly_sync;

  // Raster position; held at the origin while disabled so restart is always frame-aligned.
  always_ff @(posedge gpu_clk0 or negedge Rst_n) begin
    if (!Rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Stage 0 is combinational from the counters, gated off while disabled or in reset.
  assign run         = enable & Rst_n;
  assign pix_req     = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign pix_x       = run ? h_cnt : '0;
  assign pix_y       = run ? v_cnt : '0;
  assign line_start  = run && (h_cnt == '0);
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);

  assign raw_sync.hs = run && (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign raw_sync.vs = run && (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign raw_sync.de = pix_req;

  vt_delay_line #(
    .WIDTH (SYNC_W),
    .DEPTH (PIX_LAT)
  ) u_delay (
    .clk   (gpu_clk0),
    .rst_n (Rst_n),
    .d     (raw_sync),
    .q     (dly_sync)
  );

  // Output register: applies sync polarity and blanks RGB outside the active area.
  always_ff @(posedge gpu_clk0 or negedge Rst_n) begin
    if (!Rst_n) begin
      hsync_out <= ~HS_POL;
      vsync_out <= ~VS_POL;
      de_out    <= 1'b0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      hsync_out <= dly_sync.hs ? HS_POL : ~HS_POL;
      vsync_out <= dly_sync.vs ? VS_POL : ~VS_POL;
      de_out    <= dly_sync.de;
      red_out   <= dly_sync.de ? pix_red   : '0;
      green_out <= dly_sync.de ? pix_green : '0;
      blue_out  <= dly_sync.de ? pix_blue  : '0;
    end
  end

endmodule
